// File: rtl/fetch_unit_if.sv
// Instruction-memory bus and decode handshake bundle for fetch_unit.
// master = fetch side, slave = memory/decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_inst
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_inst
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem read, one-entry
// overflow buffer and a decode output slot with redirect squash.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        clr,
    output logic [31:0] current_pc,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master bus
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] req_pc;
    logic [31:0] slot_pc;
    logic [31:0] slot_inst;
    logic        slot_vld;
    logic [31:0] rbuf_pc;
    logic [31:0] rbuf_inst;
    logic        take;
    logic        slot_free;
    logic        unused_ok;

    assign take      = (state == S_REQ) && bus.imem_gnt;
    assign slot_free = !slot_vld || bus.if_ready;

    assign bus.imem_req  = clr && (state == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = slot_vld;
    assign bus.if_pc     = slot_pc;
    assign bus.if_inst   = slot_inst;
    assign current_pc    = pc_q;

    // Loaded PCs are always word aligned, so the low bits are ignored.
    assign unused_ok = ^{next_pc[1:0], redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc    <= 32'd0;
            slot_vld  <= 1'b0;
            slot_pc   <= 32'd0;
            slot_inst <= 32'd0;
            rbuf_pc   <= 32'd0;
            rbuf_inst <= 32'd0;
        end else begin
            if (redirect) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (take) begin
                pc_q <= {next_pc[31:2], 2'b00};
            end
            if (take) begin
                req_pc <= pc_q;
            end

            if (redirect) begin
                // Squash: a fetch still in flight must be swallowed in DROP.
                slot_vld <= 1'b0;
                case (state)
                    S_REQ:   state <= take ? S_DROP : S_REQ;
                    S_WAIT,
                    S_DROP:  state <= bus.imem_rvalid ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                if (slot_vld && bus.if_ready) begin
                    slot_vld <= 1'b0;
                end
                case (state)
                    S_REQ: begin
                        if (take) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.imem_rvalid) begin
                            if (slot_free) begin
                                slot_pc   <= req_pc;
                                slot_inst <= bus.imem_rdata;
                                slot_vld  <= 1'b1;
                                state     <= S_REQ;
                            end else begin
                                rbuf_pc   <= req_pc;
                                rbuf_inst <= bus.imem_rdata;
                                state     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (bus.if_ready) begin
                            slot_pc   <= rbuf_pc;
                            slot_inst <= rbuf_inst;
                            slot_vld  <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (bus.imem_rvalid) begin
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, pc_calculator stand-in
// and a scoreboard of expected {pc, inst} pairs seen by decode.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .clr         (clr),
        .current_pc  (current_pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_pop = 0;
    int          gap = 0;
    int          gnt_left = 0;
    int          lat = 1;
    int          resp_cnt = 0;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;

    always_comb next_pc = current_pc + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0013;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] a);
        exp_t e;
        e.pc = a;
        e.inst = inst_of(a);
        sb.push_back(e);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_req(string tag);
        for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
        chk(tag, {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic wait_resp(int target);
        for (int i = 0; i < 30 && resp_cnt < target; i++) tick();
        chk("resp_timeout", 32'(resp_cnt >= target), 32'd1);
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20 && gnt_left != 0; i++) tick();
        chk("gnt_timeout", 32'(gnt_left), 32'd0);
    endtask

    // Memory model: grants while budget remains, answers after lat cycles.
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (!clr) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = inst_of(paddr);
                    pend = 1'b0;
                    resp_cnt++;
                end else begin
                    cnt--;
                end
            end
            bus.imem_gnt = 1'b0;
            if (clr && bus.imem_req && gnt_left > 0 && !pend) begin
                bus.imem_gnt = 1'b1;
                gnt_left--;
                pend  = 1'b1;
                paddr = bus.imem_addr;
                cnt   = lat - 1;
            end
        end
    end

    // Decode-side monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (clr && bus.if_valid && bus.if_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("if_pc", bus.if_pc, e.pc);
                    chk("if_inst", bus.if_inst, e.inst);
                end
                gap = cyc - last_pop;
                last_pop = cyc;
            end
        end
    end

    initial begin
        int target;
        clr = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        bus.if_ready = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_pc", current_pc, 32'h3000);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        clr = 1'b1;
        #1;
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rel_addr", bus.imem_addr, 32'h3000);
        tick();
        chk("nognt_addr", bus.imem_addr, 32'h3000);
        chk("nognt_req", {31'd0, bus.imem_req}, 32'd1);

        // Streaming
        bus.if_ready = 1'b1;
        push(32'h3000);
        push(32'h3004);
        push(32'h3008);
        gnt_left = 3;
        drain("stream_drain");
        chk("stream_gap", 32'(gap), 32'd2);
        chk("stream_pc", current_pc, 32'h300C);
        chk("stream_valid", {31'd0, bus.if_valid}, 32'd0);

        // Backpressure into HOLD
        bus.if_ready = 1'b0;
        push(32'h300C);
        push(32'h3010);
        target = resp_cnt + 2;
        gnt_left = 2;
        wait_resp(target);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
            chk("hold_pc", bus.if_pc, 32'h300C);
            tick();
        end
        bus.if_ready = 1'b1;
        tick();
        chk("unhold_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("unhold_pc", bus.if_pc, 32'h3010);
        drain("hold_drain");

        // Redirect in WAIT
        lat = 3;
        gnt_left = 1;
        wait_gnt();
        redirect = 1'b1;
        redirect_pc = 32'h3100;
        tick();
        redirect = 1'b0;
        chk("rw_pc", current_pc, 32'h3100);
        chk("rw_req", {31'd0, bus.imem_req}, 32'd0);
        lat = 1;
        push(32'h3100);
        gnt_left = 1;
        wait_req("rw_req_to");
        chk("rw_addr", bus.imem_addr, 32'h3100);
        drain("rw_drain");

        // Redirect with coincident gnt and a held slot
        bus.if_ready = 1'b0;
        target = resp_cnt + 1;
        gnt_left = 1;
        wait_resp(target);
        chk("held_pc", bus.if_pc, 32'h3104);
        chk("held_valid", {31'd0, bus.if_valid}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h3102;
        gnt_left = 1;
        tick();
        redirect = 1'b0;
        chk("rg_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rg_pc", current_pc, 32'h3100);
        chk("rg_req", {31'd0, bus.imem_req}, 32'd0);
        bus.if_ready = 1'b1;
        push(32'h3100);
        gnt_left = 1;
        wait_req("rg_req_to");
        chk("rg_addr", bus.imem_addr, 32'h3100);
        drain("rg_drain");

        // Reset while waiting on memory
        lat = 3;
        gnt_left = 1;
        wait_gnt();
        clr = 1'b0;
        tick();
        chk("rr_pc", current_pc, 32'h3000);
        chk("rr_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rr_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rr_if_pc", bus.if_pc, 32'd0);
        chk("rr_if_inst", bus.if_inst, 32'd0);
        clr = 1'b1;
        lat = 1;
        #1;
        chk("rr_addr", bus.imem_addr, 32'h3000);
        push(32'h3000);
        gnt_left = 1;
        drain("rr_drain");
        tick();
        tick();
        chk("end_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
